// File: rtl/dht22_responder.sv
// DHT22 sensor emulator: answers a host start pulse with preamble plus a 40-bit frame.
// Optional CHECKSUM_ERR_INJ_EN adds corrupt_checksum to transmit an inverted checksum.
module dht22_responder #(
    parameter int TICK_DIV     = 50,
    parameter int START_MIN_US = 800,
    parameter int ACK_DELAY_US = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in,
    output logic        data_oe,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        enable,
`ifdef CHECKSUM_ERR_INJ_EN
    input  logic        corrupt_checksum,
`endif
    output logic        busy,
    output logic        frame_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_ACK_WAIT,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_TAIL_LOW
    } state_t;

    function automatic logic [7:0] checksum8(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_q, us_d;
    logic [5:0]    idx_q, idx_d;
    logic [39:0]   shift_q, shift_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          tick_s;
    logic          phase_end_s;
    logic          start_ok_s;
    logic [15:0]   phase_us_s;
    logic [7:0]    cks_s;

    assign tick_s      = (pre_q == PW'(TICK_DIV - 1));
    assign phase_end_s = tick_s && (us_q == phase_us_s - 16'd1);
    // Counts the current cycle too, so a pin low of exactly START_MIN_US is accepted.
    assign start_ok_s  = (us_q >= 16'(START_MIN_US)) ||
                         ((us_q == 16'(START_MIN_US - 1)) && tick_s);

    assign data_oe    = data_oe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Checksum of the live inputs, optionally inverted for host error testing.
    always_comb begin
        cks_s = checksum8({humidity, temperature});
`ifdef CHECKSUM_ERR_INJ_EN
        if (corrupt_checksum) begin
            cks_s = ~checksum8({humidity, temperature});
        end else begin
            cks_s = checksum8({humidity, temperature});
        end
`endif
    end

    // Length in microseconds of the phase held by the current state.
    always_comb begin
        case (state_q)
            S_ACK_WAIT:  phase_us_s = 16'(ACK_DELAY_US);
            S_RESP_LOW:  phase_us_s = 16'd80;
            S_RESP_HIGH: phase_us_s = 16'd80;
            S_BIT_LOW:   phase_us_s = 16'd50;
            S_BIT_HIGH:  phase_us_s = shift_q[39] ? 16'd70 : 16'd26;
            S_TAIL_LOW:  phase_us_s = 16'd50;
            default:     phase_us_s = 16'd1;
        endcase
    end

    // Next-state, frame shifter and registered output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!sync2_q && enable) state_d = S_HOST_LOW;
                else                    state_d = S_IDLE;
            end
            S_HOST_LOW: begin
                if (sync2_q) begin
                    if (start_ok_s) begin
                        state_d = S_ACK_WAIT;
                        shift_d = {humidity, temperature, cks_s};
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOST_LOW;
                end
            end
            S_ACK_WAIT:  if (phase_end_s) state_d = S_RESP_LOW;  else state_d = S_ACK_WAIT;
            S_RESP_LOW:  if (phase_end_s) state_d = S_RESP_HIGH; else state_d = S_RESP_LOW;
            S_RESP_HIGH: begin
                if (phase_end_s) begin
                    state_d = S_BIT_LOW;
                    idx_d   = 6'd39;
                end else begin
                    state_d = S_RESP_HIGH;
                end
            end
            S_BIT_LOW:   if (phase_end_s) state_d = S_BIT_HIGH;  else state_d = S_BIT_LOW;
            S_BIT_HIGH: begin
                if (phase_end_s) begin
                    if (idx_q == 6'd0) begin
                        state_d = S_TAIL_LOW;
                    end else begin
                        state_d = S_BIT_LOW;
                        idx_d   = idx_q - 6'd1;
                        shift_d = {shift_q[38:0], 1'b0};
                    end
                end else begin
                    state_d = S_BIT_HIGH;
                end
            end
            S_TAIL_LOW:  if (phase_end_s) state_d = S_IDLE;      else state_d = S_TAIL_LOW;
            default:     state_d = S_IDLE;
        endcase

        data_oe_d    = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) ||
                       (state_d == S_TAIL_LOW);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HOST_LOW);
        frame_done_d = (state_q == S_TAIL_LOW) && (state_d == S_IDLE);
    end

    // Microsecond prescaler and counter; restart on every state change.
    always_comb begin
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            pre_d = '0;
            us_d  = 16'd0;
        end else if (tick_s) begin
            pre_d = '0;
            us_d  = (us_q == 16'hFFFF) ? us_q : us_q + 16'd1;
        end else begin
            pre_d = pre_q + PW'(1);
            us_d  = us_q;
        end
    end

    // Two-flop synchronizer; idles high like the pulled-up line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    // State, timing and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            us_q         <= 16'd0;
            idx_q        <= 6'd0;
            shift_q      <= 40'd0;
            data_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            us_q         <= us_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_oe_q    <= data_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
